// File: rtl/sipo_pkg.sv
// Shared constants, holding-register state type and counter sizing for the deserializer.
package sipo_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input, parallel output and status bundle of the deserializer.
interface sipo_deser_if
   import sipo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = cnt_w(WIDTH)
);
   logic             SIN;
   logic             SIN_EN;
   logic             SYNC;
   logic [WIDTH-1:0] POUT;
   logic             POUT_VALID;
   logic             POUT_READY;
   logic             OVERRUN;
   logic             CLR_OVR;
   logic [CNT_W-1:0] BIT_CNT;

   modport master (
      input  SIN, SIN_EN, SYNC, POUT_READY, CLR_OVR,
      output POUT, POUT_VALID, OVERRUN, BIT_CNT
   );

   modport slave (
      output SIN, SIN_EN, SYNC, POUT_READY, CLR_OVR,
      input  POUT, POUT_VALID, OVERRUN, BIT_CNT
   );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; flags the edge that samples the last bit of a word.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sync,
   output logic             word_done,
   output logic [WIDTH-1:0] word_data,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // Only WIDTH-1 bits need storing: the final bit is taken straight from sin.
   logic [WIDTH-2:0] shreg;
   logic [CNT_W-1:0] cnt;

   assign word_data = {shreg, sin};
   assign word_done = sin_en & ~sync & (cnt == LAST_BIT);
   assign bit_cnt   = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (sync) begin
         if (sin_en) begin
            shreg <= {{(WIDTH-2){1'b0}}, sin};
            cnt   <= CNT_W'(1);
         end else begin
            shreg <= '0;
            cnt   <= '0;
         end
      end else if (sin_en) begin
         shreg <= word_data[WIDTH-2:0];
         cnt   <= word_done ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: shift core plus a one-word holding register
// with valid/ready handoff and a sticky overrun flag.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = cnt_w(WIDTH)
) (
   input  logic         CLK,
   input  logic         RST,
   sipo_deser_if.master bus
);

   logic             word_done;
   logic [WIDTH-1:0] word_data;
   logic [CNT_W-1:0] bit_cnt;

   hold_state_t      state_q, state_d;
   logic [WIDTH-1:0] pout_q, pout_d;
   logic             ovr_q, ovr_d;
   logic             accept;
   logic             ovr_set;

   sipo_shift_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk       (CLK),
      .rst       (RST),
      .sin       (bus.SIN),
      .sin_en    (bus.SIN_EN),
      .sync      (bus.SYNC),
      .word_done (word_done),
      .word_data (word_data),
      .bit_cnt   (bit_cnt)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= HOLD_EMPTY;
         pout_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pout_q  <= pout_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pout_d  = pout_q;
      ovr_set = 1'b0;
      accept  = (state_q == HOLD_FULL) & bus.POUT_READY;
      case (state_q)
         HOLD_EMPTY: begin
            if (word_done) begin
               pout_d  = word_data;
               state_d = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            if (word_done) begin
               if (accept) pout_d  = word_data;
               else        ovr_set = 1'b1;
            end else if (accept) begin
               state_d = HOLD_EMPTY;
            end
         end
         default: state_d = HOLD_EMPTY;
      endcase
      // A fresh overrun outranks a simultaneous clear request.
      ovr_d = ovr_set | (ovr_q & ~bus.CLR_OVR);
   end

   assign bus.POUT       = pout_q;
   assign bus.POUT_VALID = (state_q == HOLD_FULL);
   assign bus.OVERRUN    = ovr_q;
   assign bus.BIT_CNT    = bit_cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed and randomized checks of sipo_deser against a queue-based word model.
module tb_sipo_deser;
   import sipo_pkg::*;

   localparam int W  = 4;
   localparam int CW = cnt_w(W);

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   sipo_deser_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   sipo_deser #(.WIDTH(W), .CNT_W(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;

   bit          m_bits[$];
   logic [W-1:0] m_pout;
   logic        m_valid;
   logic        m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_pout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_step(input bit s, en, sy, rdy, clr);
      bit           done = 1'b0;
      bit           ovr_set = 1'b0;
      logic [W-1:0] cand = '0;
      if (sy) begin
         m_bits.delete();
         if (en) m_bits.push_back(s);
      end else if (en) begin
         m_bits.push_back(s);
         if (m_bits.size() == W) begin
            done = 1'b1;
            for (int i = 0; i < W; i++) cand[W-1-i] = m_bits[i];
            m_bits.delete();
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_pout  = cand;
            m_valid = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      m_ovr = ovr_set | (m_ovr & ~clr);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pout"},    32'(bus.POUT),       32'(m_pout));
      check({tag, ".valid"},   32'(bus.POUT_VALID), 32'(m_valid));
      check({tag, ".overrun"}, 32'(bus.OVERRUN),    32'(m_ovr));
      check({tag, ".bit_cnt"}, 32'(bus.BIT_CNT),    32'(m_bits.size()));
   endtask

   task automatic cycle(input string tag, input bit s, en, sy, rdy, clr);
      bus.SIN        = s;
      bus.SIN_EN     = en;
      bus.SYNC       = sy;
      bus.POUT_READY = rdy;
      bus.CLR_OVR    = clr;
      @(posedge CLK);
      model_step(s, en, sy, rdy, clr);
      #1;
      check_all(tag);
   endtask

   task automatic send_word(input string tag, input logic [W-1:0] w, input bit rdy);
      for (int i = W - 1; i >= 0; i--) cycle(tag, w[i], 1'b1, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      bus.SIN = 0; bus.SIN_EN = 0; bus.SYNC = 0; bus.POUT_READY = 0; bus.CLR_OVR = 0;
      model_reset();
      #2;
      check_all("reset");
      #10;
      RST = 1'b0;

      // Basic word with downstream always ready; valid lasts one cycle
      cycle("t1b0", 1, 1, 0, 1, 0);
      check("t1.cnt1", 32'(bus.BIT_CNT), 32'd1);
      cycle("t1b1", 0, 1, 0, 1, 0);
      check("t1.cnt2", 32'(bus.BIT_CNT), 32'd2);
      cycle("t1b2", 1, 1, 0, 1, 0);
      check("t1.cnt3", 32'(bus.BIT_CNT), 32'd3);
      cycle("t1b3", 1, 1, 0, 1, 0);
      check("t1.word", 32'(bus.POUT), 32'hB);
      check("t1.valid_hi", 32'(bus.POUT_VALID), 32'd1);
      check("t1.cnt0", 32'(bus.BIT_CNT), 32'd0);
      cycle("t1idle", 0, 0, 0, 1, 0);
      check("t1.valid_lo", 32'(bus.POUT_VALID), 32'd0);

      // Stalled downstream: second word dropped
      send_word("t2a", 4'b0110, 1'b0);
      send_word("t2b", 4'b1001, 1'b0);
      check("t2.held", 32'(bus.POUT), 32'h6);
      check("t2.ovr", 32'(bus.OVERRUN), 32'd1);
      cycle("t2clr", 0, 0, 0, 0, 1);
      check("t2.ovr_clr", 32'(bus.OVERRUN), 32'd0);
      check("t2.still", 32'(bus.POUT), 32'h6);

      // Accept coinciding with completion replaces the word without overrun
      cycle("t3b0", 1, 1, 0, 0, 0);
      cycle("t3b1", 1, 1, 0, 0, 0);
      cycle("t3b2", 0, 1, 0, 0, 0);
      cycle("t3b3", 0, 1, 0, 1, 0);
      check("t3.word", 32'(bus.POUT), 32'hC);
      check("t3.valid", 32'(bus.POUT_VALID), 32'd1);
      check("t3.ovr", 32'(bus.OVERRUN), 32'd0);
      cycle("t3drain", 0, 0, 0, 1, 0);

      // Realign mid-word; the bit sampled with SYNC starts the new frame
      cycle("t4b0", 1, 1, 0, 1, 0);
      cycle("t4b1", 1, 1, 0, 1, 0);
      cycle("t4sync", 0, 1, 1, 1, 0);
      check("t4.cnt", 32'(bus.BIT_CNT), 32'd1);
      cycle("t4b2", 1, 1, 0, 1, 0);
      cycle("t4b3", 0, 1, 0, 1, 0);
      cycle("t4b4", 1, 1, 0, 1, 0);
      check("t4.word", 32'(bus.POUT), 32'h5);

      // Gapped strobe: SIN ignored when SIN_EN is low
      cycle("t5a", 1, 1, 0, 1, 0);
      cycle("t5b", 1'($urandom), 0, 0, 1, 0);
      cycle("t5c", 1'($urandom), 0, 0, 1, 0);
      cycle("t5d", 0, 1, 0, 1, 0);
      cycle("t5e", 0, 1, 0, 1, 0);
      cycle("t5f", 1'($urandom), 0, 0, 1, 0);
      cycle("t5g", 1, 1, 0, 1, 0);
      check("t5.word", 32'(bus.POUT), 32'h9);

      // Asynchronous reset with a held word and a partial word
      send_word("t6hold", 4'b1010, 1'b0);
      cycle("t6p0", 1, 1, 0, 0, 0);
      cycle("t6p1", 0, 1, 0, 0, 0);
      cycle("t6p2", 1, 1, 0, 0, 0);
      RST = 1'b1;
      #1;
      model_reset();
      check_all("t6rst");
      check("t6.pout0", 32'(bus.POUT), 32'h0);
      #2;
      RST = 1'b0;
      send_word("t6post", 4'b1110, 1'b0);
      check("t6.word", 32'(bus.POUT), 32'hE);
      cycle("t6drain", 0, 0, 0, 1, 1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         cycle("rnd", 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
               1'($urandom), $urandom_range(0, 9) == 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer; the receive end of the 4-bit parallel-to-serial shift link.
- Collects WIDTH serial bits, MSB first, qualified by a bit strobe.
- Presents each completed word on a parallel bus with a valid/ready handshake.
- Flags dropped words when downstream stalls.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset; clears all state.
- SIN  input  1  serial data bit.
- SIN_EN  input  1  bit strobe; SIN is sampled only on CLK edges where SIN_EN=1.
- SYNC  input  1  frame realign; discards any partial word.
- POUT  output  WIDTH  assembled word; first received bit is in POUT[WIDTH-1].
- POUT_VALID  output  1  POUT holds an unconsumed word.
- POUT_READY  input  1  downstream accepts the word when POUT_VALID=1.
- OVERRUN  output  1  sticky flag: a completed word was dropped.
- CLR_OVR  input  1  synchronous clear of OVERRUN.
- BIT_CNT  output  CNT_W  bits of the current partial word received so far (0..WIDTH-1).

Behaviour:
- Reset (asynchronous, immediate): shift register=0, BIT_CNT=0, POUT=0, POUT_VALID=0, OVERRUN=0.
- Reset asserted mid-word discards the partial word and any held word.
- Shift on SIN_EN=1: shreg <= {shreg[WIDTH-2:0], SIN}; BIT_CNT increments.
- Word completion: the edge on which SIN_EN=1 and BIT_CNT==WIDTH-1.
  - The completed word {shreg[WIDTH-2:0], SIN} is the candidate word.
  - BIT_CNT wraps to 0 on the same edge, so back-to-back words need no gap cycle.
- Holding register FSM, two states:
  - EMPTY (POUT_VALID=0): on completion, POUT <= candidate; go to FULL.
  - FULL (POUT_VALID=1): POUT stays stable until accepted. Accept = POUT_VALID & POUT_READY.
    - Accept, no completion: go to EMPTY; POUT keeps its last value.
    - Accept and completion on the same edge: POUT <= candidate; stay FULL; no overrun.
    - Completion without accept: candidate is dropped, POUT is unchanged, OVERRUN <= 1.
- POUT_READY while EMPTY is ignored.
- Latency: POUT_VALID rises on the edge that samples the last bit, so it is visible in the following cycle.
- SYNC=1: shreg <= 0 and BIT_CNT <= 0; the held word and POUT_VALID are unaffected.
- SYNC and SIN_EN both high on the same edge: SIN is taken as bit 0 of the new frame. BIT_CNT=1 and shreg={0..0,SIN}.
- SYNC never produces a completion, even when BIT_CNT==WIDTH-1.
- OVERRUN stays 1 until CLR_OVR=1.
- CLR_OVR and a new overrun on the same edge: the set wins, OVERRUN stays 1.
- Fully synchronous except RST; no combinational path from inputs to outputs.

Decomposition:
- Package sipo_pkg:
  - Default WIDTH constant.
  - Holding-state enum {HOLD_EMPTY, HOLD_FULL}.
  - Function to compute CNT_W.
- One sub-module, sipo_shift_core:
  - Contains the shift register and bit counter, with SYNC handling.
  - Outputs word_done pulse, word_data, and BIT_CNT.
- The top level holds the holding-register FSM and the OVERRUN logic.

Test Plan:
- Reset, then SIN_EN=1 each cycle with SIN=1,0,1,1 and POUT_READY=1 -> POUT=4'b1011, POUT_VALID high for exactly 1 cycle, BIT_CNT sequence 1,2,3,0.
- Send 4'b0110, then 4'b1001 continuously with POUT_READY=0 -> POUT=0110 held, OVERRUN=1 after the 8th bit. Then pulse CLR_OVR -> OVERRUN=0, POUT still 0110.
- POUT_READY=1 exactly on the edge that completes the second word 1100 -> POUT=1100, POUT_VALID stays 1, OVERRUN=0.
- Send bits 1,1, then SYNC with SIN_EN=1, SIN=0, then bits 1,0,1 -> POUT=4'b0101, BIT_CNT=1 right after SYNC.
- SIN_EN gapped (1,0,0,1,1,0,1) with bits 1,x,x,0,0,x,1 -> POUT=4'b1001; SIN ignored while SIN_EN=0.
- Assert RST after 3 bits while a word is held -> all outputs 0 immediately. Next 4 bits 1,1,1,0 -> POUT=4'b1110.
